elim_sched: RTL and testbench

- Command scheduler that sequences GF(2) Gaussian-elimination systemization of an N-row matrix held in the elimination datapath's row memory.
- For each pivot column it:
  - issues PROBE commands to find a row with a 1 in that column,
  - issues a SWAP when the pivot row is not already in place,
  - issues ELIM commands to clear the column in every other row.
- It drives the datapath through a valid/ready command port and reports done/fail to the top-level start/done interface.

---
 rtl/elim_sched.sv | 166 ++++++++++++++++
 tb/tb_elim_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elim_sched.sv
// Command scheduler for GF(2) Gaussian-elimination systemization: walks pivots,
// probes for a pivot row, swaps it into place and clears the column elsewhere.
module elim_sched #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         done,
  output logic         fail,
  output logic         busy,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [1:0]   cmd_op,
  output logic [W-1:0] cmd_pivot,
  output logic [W-1:0] cmd_row,
  input  logic         rsp_valid,
  input  logic         rsp_bit,
  output logic [2:0]   dbg_state_o
);

  // Command port: a command transfers on a rising edge with cmd_valid && cmd_ready.
  // Once raised, cmd_valid stays high and op/pivot/row stay frozen until that
  // transfer (only rst can withdraw it); one command is outstanding at a time, and
  // rsp_valid is only honoured while waiting for a PROBE result.
  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W-1:0] LAST2 = W'(N - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROBE = 3'd1,
    S_PWAIT = 3'd2,
    S_SWAP  = 3'd3,
    S_ELIM  = 3'd4,
    S_NEXT  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] e_q, e_d;
  logic         fail_q, fail_d;
  logic         done_q;
  logic         busy_q;
  logic         cmd_valid_q;
  logic [1:0]   cmd_op_q;
  logic [W-1:0] cmd_pivot_q;
  logic [W-1:0] cmd_row_q;

  logic         hs;
  logic [W-1:0] first_e;
  logic [W-1:0] e_inc;
  logic [W-1:0] next_e;
  logic [W-1:0] last_e;

  assign hs      = cmd_valid_q & cmd_ready;
  // The pivot row is skipped without spending a cycle on it.
  assign first_e = (p_q == '0) ? W'(1) : '0;
  assign e_inc   = e_q + W'(1);
  assign next_e  = (e_inc == p_q) ? e_q + W'(2) : e_inc;
  assign last_e  = (p_q == LAST) ? LAST2 : LAST;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    r_d     = r_q;
    e_d     = e_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = '0;
          r_d     = '0;
          fail_d  = 1'b0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (hs) state_d = S_PWAIT;
      end
      S_PWAIT: begin
        if (rsp_valid) begin
          if (rsp_bit) begin
            if (r_q == p_q) begin
              e_d     = first_e;
              state_d = S_ELIM;
            end else begin
              state_d = S_SWAP;
            end
          end else if (r_q == LAST) begin
            fail_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            r_d     = r_q + W'(1);
            state_d = S_PROBE;
          end
        end
      end
      S_SWAP: begin
        if (hs) begin
          e_d     = first_e;
          state_d = S_ELIM;
        end
      end
      S_ELIM: begin
        if (hs) begin
          if (e_q == last_e) state_d = S_NEXT;
          else               e_d     = next_e;
        end
      end
      S_NEXT: begin
        if (p_q == LAST) begin
          state_d = S_FIN;
        end else begin
          p_d     = p_q + W'(1);
          r_d     = p_q + W'(1);
          state_d = S_PROBE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      r_q         <= '0;
      e_q         <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 2'b00;
      cmd_pivot_q <= '0;
      cmd_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      r_q         <= r_d;
      e_q         <= e_d;
      fail_q      <= fail_d;
      done_q      <= (state_d == S_FIN);
      busy_q      <= (state_d != S_IDLE);
      cmd_valid_q <= (state_d == S_PROBE) || (state_d == S_SWAP) || (state_d == S_ELIM);
      cmd_op_q    <= (state_d == S_SWAP) ? 2'b01 :
                     (state_d == S_ELIM) ? 2'b10 : 2'b00;
      cmd_pivot_q <= p_d;
      cmd_row_q   <= (state_d == S_ELIM) ? e_d : r_d;
    end
  end

  assign done        = done_q;
  assign fail        = fail_q;
  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_pivot   = cmd_pivot_q;
  assign cmd_row     = cmd_row_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_elim_sched.sv
// Bench for elim_sched (N=4): emulates the row-memory datapath and checks the
// command stream against a direct Gaussian-elimination reference.
module tb_elim_sched;
  localparam int N      = 4;
  localparam int W      = 2;
  localparam int CW     = 2 + 2 * W;
  localparam int BUDGET = 2000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic         fail;
  logic         busy;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_pivot;
  logic [W-1:0] cmd_row;
  logic         rsp_valid;
  logic         rsp_bit;
  logic [2:0]   dbg_state;

  elim_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .fail(fail), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pivot(cmd_pivot), .cmd_row(cmd_row), .rsp_valid(rsp_valid),
    .rsp_bit(rsp_bit), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [N-1:0]  mem   [N];
  logic [N-1:0]  exp_m [N];
  logic [CW-1:0] exp_q [$];
  int            exp_done;
  int            exp_n;
  bit            exp_fail;

  bit stall_en;
  bit bp_en;
  bit spur_en;
  int rst_pivot;

  int n_probe, n_swap, n_elim;

  // Reference: plain Gaussian elimination over GF(2) producing the command list.
  task automatic build_expected();
    logic [N-1:0] t;
    int  r;
    bit  found;
    exp_q.delete();
    exp_fail = 0;
    exp_done = 1;
    for (int i = 0; i < N; i++) exp_m[i] = mem[i];
    for (int p = 0; p < N && !exp_fail; p++) begin
      found = 0;
      r = p;
      while (r < N && !found) begin
        exp_q.push_back({2'b00, W'(p), W'(r)});
        exp_done += 2;
        if (exp_m[r][p]) found = 1;
        else r++;
      end
      if (!found) begin
        exp_fail = 1;
      end else begin
        if (r != p) begin
          exp_q.push_back({2'b01, W'(p), W'(r)});
          exp_done += 1;
          t = exp_m[r]; exp_m[r] = exp_m[p]; exp_m[p] = t;
        end
        for (int e = 0; e < N; e++) begin
          if (e != p) begin
            exp_q.push_back({2'b10, W'(p), W'(e)});
            if (exp_m[e][p]) exp_m[e] = exp_m[e] ^ exp_m[p];
          end
        end
        exp_done += (N - 1) + 1;
      end
    end
    exp_n = exp_q.size();
  endtask

  task automatic run_sched(input string name);
    int cyc;
    int got_done;
    bit got_fail;
    bit fail_c1;
    bit pend, pend_bit;
    bit prev_stall;
    logic [CW-1:0] prev_cmd, cur, want;
    int busy_err, proto_err, bp_stall, bp_hs, n_hs;
    bit rst_arm, aborted;
    logic [N-1:0] t;
    got_done = -1; got_fail = 0; fail_c1 = 1; pend = 0; pend_bit = 0;
    prev_stall = 0; prev_cmd = '0; busy_err = 0; proto_err = 0;
    bp_stall = 0; bp_hs = 0; n_hs = 0; rst_arm = 0; aborted = 0;
    n_probe = 0; n_swap = 0; n_elim = 0;
    build_expected();
    @(negedge clk);
    start = 1; cmd_ready = 1; rsp_valid = 0; rsp_bit = 0;
    for (cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start = 0; rsp_valid = 0; rsp_bit = 0;
      cur = {cmd_op, cmd_pivot, cmd_row};
      if (cyc == 1) fail_c1 = fail;
      if (done === 1'b1) begin
        got_done = cyc; got_fail = fail;
        if (busy !== 1'b1) busy_err++;
        break;
      end
      if (busy !== 1'b1) busy_err++;
      if (cmd_valid === 1'b1 && cmd_op === 2'b11) proto_err++;
      if (prev_stall && (cmd_valid !== 1'b1 || cur !== prev_cmd)) proto_err++;
      if (pend && cmd_valid !== 1'b0) proto_err++;
      if (rst_arm) begin
        rst = 1; pend = 0; aborted = 1;
        break;
      end
      if (pend) begin
        rsp_valid = 1; rsp_bit = pend_bit; pend = 0;
      end else if (spur_en && cmd_valid && cmd_op == 2'b10) begin
        rsp_valid = 1; rsp_bit = 1'($urandom_range(0, 1));
      end
      if (spur_en && (cyc == 3 || cyc == 8 || cyc == 14)) start = 1;
      cmd_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bp_en && bp_stall > 0 && bp_stall < 3) begin
        cmd_ready = 0; bp_stall++;
        tests++;
        if (cmd_valid !== 1'b1 || cur !== {2'b10, 2'd1, 2'd2}) begin
          fails++;
          $display("FAIL %s bp_hold: got valid=%b cmd=%h, want valid=1 cmd=%h",
                   name, cmd_valid, cur, {2'b10, 2'd1, 2'd2});
        end
      end else if (bp_en && bp_stall == 0 && cmd_valid && cur == {2'b10, 2'd1, 2'd2}) begin
        cmd_ready = 0; bp_stall = 1;
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd   = cur;
      if (cmd_valid === 1'b1 && cmd_ready) begin
        n_hs++;
        tests++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if (cur !== want) begin
          fails++;
          $display("FAIL %s cmd#%0d: got op=%b p=%0d r=%0d, want op=%b p=%0d r=%0d",
                   name, n_hs, cmd_op, cmd_pivot, cmd_row, want[CW-1 -: 2],
                   want[2*W-1 -: W], want[W-1:0]);
        end
        if (cur == {2'b10, 2'd1, 2'd2}) bp_hs++;
        case (cmd_op)
          2'b00: begin
            n_probe++;
            pend = 1; pend_bit = mem[cmd_row][cmd_pivot];
            if (rst_pivot >= 0 && int'(cmd_pivot) == rst_pivot) rst_arm = 1;
          end
          2'b01: begin
            n_swap++;
            t = mem[cmd_row]; mem[cmd_row] = mem[cmd_pivot]; mem[cmd_pivot] = t;
          end
          2'b10: begin
            n_elim++;
            if (mem[cmd_row][cmd_pivot]) mem[cmd_row] = mem[cmd_row] ^ mem[cmd_pivot];
          end
          default: ;
        endcase
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst = 0;
      tests++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s after_rst: got busy=%b valid=%b done=%b, want 0 0 0",
                 name, busy, cmd_valid, done);
      end
      proto_err = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b0) proto_err++;
      end
      tests++;
      if (proto_err != 0) begin
        fails++;
        $display("FAIL %s quiet_after_rst: got %0d active cycles, want 0", name, proto_err);
      end
      return;
    end

    tests++;
    if (got_done < 0) begin
      fails++;
      $display("FAIL %s timeout: got no done in %0d cycles, want done", name, BUDGET);
    end
    tests++;
    if (got_fail !== exp_fail) begin
      fails++;
      $display("FAIL %s fail_flag: got %b, want %b", name, got_fail, exp_fail);
    end
    tests++;
    if (n_hs != exp_n || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s cmd_count: got %0d, want %0d", name, n_hs, exp_n);
    end
    tests++;
    if (fail_c1 !== 1'b0) begin
      fails++;
      $display("FAIL %s fail_cleared: got %b at cycle 1, want 0", name, fail_c1);
    end
    if (!stall_en) begin
      tests++;
      if (got_done != exp_done + bp_stall) begin
        fails++;
        $display("FAIL %s done_cycle: got %0d, want %0d", name, got_done, exp_done + bp_stall);
      end
    end
    if (bp_en) begin
      tests++;
      if (bp_stall != 3 || bp_hs != 1) begin
        fails++;
        $display("FAIL %s bp_handshakes: got stall=%0d hs=%0d, want 3 1", name, bp_stall, bp_hs);
      end
    end
    tests++;
    if (busy_err != 0 || proto_err != 0) begin
      fails++;
      $display("FAIL %s protocol: got busy_err=%0d proto_err=%0d, want 0 0",
               name, busy_err, proto_err);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (mem[i] !== exp_m[i]) begin
        fails++;
        $display("FAIL %s row%0d: got %b, want %b", name, i, mem[i], exp_m[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== exp_fail) begin
      fails++;
      $display("FAIL %s post_done: got busy=%b done=%b fail=%b, want 0 0 %b",
               name, busy, done, fail, exp_fail);
    end
  endtask

  task automatic clear_opts();
    stall_en = 0; bp_en = 0; spur_en = 0; rst_pivot = -1;
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++) mem[i] = N'(1) << i;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; cmd_ready = 0; rsp_valid = 0; rsp_bit = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({done, fail, busy, cmd_valid} !== 4'b0000 || cmd_op !== 2'b00 ||
        cmd_pivot !== '0 || cmd_row !== '0 || dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL reset: got done=%b fail=%b busy=%b valid=%b op=%b p=%0d r=%0d st=%0d, want all 0",
               done, fail, busy, cmd_valid, cmd_op, cmd_pivot, cmd_row, dbg_state);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    clear_opts();
    load_identity();
    run_sched("identity");
    tests++;
    if (n_probe != 4 || n_swap != 0 || n_elim != 12 || exp_done != 25) begin
      fails++;
      $display("FAIL identity_mix: got probe=%0d swap=%0d elim=%0d, want 4 0 12",
               n_probe, n_swap, n_elim);
    end
  endtask

  task automatic test_swap();
    clear_opts();
    mem[0] = 4'b0010; mem[1] = 4'b0100; mem[2] = 4'b0001; mem[3] = 4'b1000;
    run_sched("swap");
    tests++;
    if (n_swap < 1) begin
      fails++;
      $display("FAIL swap_count: got %0d, want >=1", n_swap);
    end
  endtask

  task automatic test_all_zero();
    clear_opts();
    for (int i = 0; i < N; i++) mem[i] = '0;
    run_sched("all_zero");
    tests++;
    if (n_probe != 4 || n_swap != 0 || n_elim != 0) begin
      fails++;
      $display("FAIL zero_mix: got probe=%0d swap=%0d elim=%0d, want 4 0 0",
               n_probe, n_swap, n_elim);
    end
    load_identity();
    run_sched("after_fail");
  endtask

  task automatic test_backpressure();
    clear_opts();
    bp_en = 1;
    load_identity();
    run_sched("backpressure");
  endtask

  task automatic test_spurious();
    clear_opts();
    spur_en = 1;
    load_identity();
    run_sched("spurious_id");
    mem[0] = 4'b0010; mem[1] = 4'b0100; mem[2] = 4'b0001; mem[3] = 4'b1000;
    run_sched("spurious_swap");
  endtask

  task automatic test_reset_mid_run();
    clear_opts();
    rst_pivot = 2;
    load_identity();
    run_sched("mid_reset");
    clear_opts();
    load_identity();
    run_sched("rerun");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      clear_opts();
      stall_en = (k % 2 == 1);
      for (int i = 0; i < N; i++) mem[i] = N'($urandom_range(0, (1 << N) - 1));
      run_sched($sformatf("random%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_swap();
    test_all_zero();
    test_backpressure();
    test_spurious();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
